// File: rtl/mem_line_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_line_ctrl_pkg : shared sizes, FSM states and requester ids
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_line_ctrl_pkg;

  localparam int unsigned MEMC_ADDR_W  = 32;
  localparam int unsigned MEMC_LINE_W  = 128;
  localparam int unsigned MEMC_IDX_W   = 12;
  localparam int unsigned MEMC_LATENCY = 5;

  typedef enum logic [1:0] {
    MEMC_IDLE = 2'd0,
    MEMC_WB   = 2'd1,
    MEMC_READ = 2'd2,
    MEMC_RESP = 2'd3
  } memc_state_e;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } memc_owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_line_array.sv
// ---------------------------------------------------------------------------
// mem_line_array : line backing store, one write port, async read port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_line_array
  import mem_line_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W  = MEMC_IDX_W,
  parameter int unsigned LINE_W = MEMC_LINE_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [LINE_W-1:0] rdata_o
);

  // Contents are deliberately not reset; they model DRAM.
  logic [LINE_W-1:0] mem_q [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/mem_line_ctrl.sv
// ---------------------------------------------------------------------------
// mem_line_ctrl : fixed-latency line fill / writeback server for I$ and D$
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_line_ctrl
  import mem_line_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = MEMC_ADDR_W,
  parameter int unsigned LINE_W      = MEMC_LINE_W,
  parameter int unsigned MEM_IDX_W   = MEMC_IDX_W,
  parameter int unsigned MEM_LATENCY = MEMC_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rdy,
  output logic [LINE_W-1:0] ic_data,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_wb,
  input  logic [ADDR_W-1:0] dc_wb_addr,
  input  logic [LINE_W-1:0] dc_wb_data,
  output logic              dc_rdy,
  output logic [LINE_W-1:0] dc_data,
  output logic              busy
);

  localparam int unsigned          IDX_LO     = 4;
  localparam int unsigned          IDX_HI     = IDX_LO + MEM_IDX_W - 1;
  localparam int unsigned          CNT_W      = $clog2(MEM_LATENCY);
  localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(MEM_LATENCY - 1);

  memc_state_e          state_q, state_d;
  memc_owner_e          owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MEM_IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic [MEM_IDX_W-1:0] wb_idx_q, wb_idx_d;
  logic [LINE_W-1:0]    wb_data_q, wb_data_d;
  logic [LINE_W-1:0]    ic_data_q, ic_data_d;
  logic [LINE_W-1:0]    dc_data_q, dc_data_d;
  logic                 mem_we;
  logic [LINE_W-1:0]    mem_rdata;

  // Byte offset and aliasing upper bits play no part in line selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr[ADDR_W-1:IDX_HI+1], ic_addr[IDX_LO-1:0],
                              dc_addr[ADDR_W-1:IDX_HI+1], dc_addr[IDX_LO-1:0],
                              dc_wb_addr[ADDR_W-1:IDX_HI+1], dc_wb_addr[IDX_LO-1:0]};

  mem_line_array #(
    .IDX_W  (MEM_IDX_W),
    .LINE_W (LINE_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wb_idx_q),
    .wdata_i (wb_data_q),
    .raddr_i (fill_idx_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MEMC_IDLE;
      owner_q    <= OWNER_IC;
      cnt_q      <= '0;
      fill_idx_q <= '0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      ic_data_q  <= '0;
      dc_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      fill_idx_q <= fill_idx_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      ic_data_q  <= ic_data_d;
      dc_data_q  <= dc_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    fill_idx_d = fill_idx_q;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    ic_data_d  = ic_data_q;
    dc_data_d  = dc_data_q;
    mem_we     = 1'b0;
    ic_rdy     = 1'b0;
    dc_rdy     = 1'b0;

    unique case (state_q)
      MEMC_IDLE: begin
        if (dc_req) begin
          owner_d    = OWNER_DC;
          fill_idx_d = dc_addr[IDX_HI:IDX_LO];
          wb_idx_d   = dc_wb_addr[IDX_HI:IDX_LO];
          wb_data_d  = dc_wb_data;
          cnt_d      = CNT_RELOAD;
          state_d    = dc_wb ? MEMC_WB : MEMC_READ;
        end else if (ic_req) begin
          owner_d    = OWNER_IC;
          fill_idx_d = ic_addr[IDX_HI:IDX_LO];
          cnt_d      = CNT_RELOAD;
          state_d    = MEMC_READ;
        end
      end
      MEMC_WB: begin
        if (cnt_q == '0) begin
          // A reset landing on the final WB cycle must drop the write.
          mem_we  = !reset;
          cnt_d   = CNT_RELOAD;
          state_d = MEMC_READ;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MEMC_READ: begin
        if (cnt_q == '0) begin
          if (owner_q == OWNER_DC) begin
            dc_data_d = mem_rdata;
          end else begin
            ic_data_d = mem_rdata;
          end
          state_d = MEMC_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MEMC_RESP: begin
        ic_rdy  = (owner_q == OWNER_IC);
        dc_rdy  = (owner_q == OWNER_DC);
        state_d = MEMC_IDLE;
      end
      default: state_d = MEMC_IDLE;
    endcase
  end

  assign busy    = (state_q != MEMC_IDLE);
  assign ic_data = ic_data_q;
  assign dc_data = dc_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_line_ctrl : directed self-checking bench for mem_line_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_line_ctrl;

  localparam logic [127:0] LINE_AD  = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
  localparam logic [127:0] LINE_W80 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
  localparam logic [127:0] LINE_P   = 128'h5A5A5A5A_A5A5A5A5_01234567_89ABCDEF;
  localparam logic [127:0] LINE_Q   = 128'hDEADBEEF_CAFEF00D_BAADF00D_FEEDFACE;
  localparam logic [127:0] LINE_JNK = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ic_req = 1'b0;
  logic [31:0]  ic_addr = '0;
  logic         ic_rdy;
  logic [127:0] ic_data;
  logic         dc_req = 1'b0;
  logic [31:0]  dc_addr = '0;
  logic         dc_wb = 1'b0;
  logic [31:0]  dc_wb_addr = '0;
  logic [127:0] dc_wb_data = '0;
  logic         dc_rdy;
  logic [127:0] dc_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  mem_line_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .ic_req     (ic_req),
    .ic_addr    (ic_addr),
    .ic_rdy     (ic_rdy),
    .ic_data    (ic_data),
    .dc_req     (dc_req),
    .dc_addr    (dc_addr),
    .dc_wb      (dc_wb),
    .dc_wb_addr (dc_wb_addr),
    .dc_wb_data (dc_wb_data),
    .dc_rdy     (dc_rdy),
    .dc_data    (dc_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete request: drive, wait for the owner's pulse, check latency,
  // data, the other rdy staying low, and a single-cycle pulse.
  task automatic txn(input bit is_dc, input logic [31:0] addr, input bit wb,
                     input logic [31:0] wb_addr, input logic [127:0] wb_data,
                     input int exp_lat, input logic [127:0] exp_data,
                     input bit disturb, input string tag);
    int           lat;
    bit           other_seen;
    logic [127:0] got;
    lat = -1;
    other_seen = 1'b0;
    got = '0;
    if (is_dc) begin
      dc_req = 1'b1; dc_addr = addr; dc_wb = wb;
      dc_wb_addr = wb_addr; dc_wb_data = wb_data;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end
    tick();
    chk($sformatf("%s busy_after_accept", tag), 128'(busy), 128'(1));
    if (disturb) begin
      ic_addr = 32'h0000_0100;
      dc_addr = 32'h0000_0100;
      dc_wb = 1'b1;
      dc_wb_addr = 32'h0000_0040;
      dc_wb_data = LINE_JNK;
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (is_dc ? ic_rdy : dc_rdy) other_seen = 1'b1;
      if (is_dc ? dc_rdy : ic_rdy) begin
        lat = k;
        got = is_dc ? dc_data : ic_data;
        break;
      end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    dc_wb  = 1'b0;
    chk($sformatf("%s latency", tag), 128'(lat), 128'(exp_lat));
    chk($sformatf("%s data", tag), got, exp_data);
    chk($sformatf("%s other_rdy", tag), 128'(other_seen), 128'(0));
    tick();
    chk($sformatf("%s rdy_single_pulse", tag), 128'(is_dc ? dc_rdy : ic_rdy), 128'(0));
    chk($sformatf("%s idle_after", tag), 128'(busy), 128'(0));
  endtask

  initial begin
    int           dc_at, ic_at, dc_cnt, ic_cnt, busy_bad, both;
    logic [127:0] got_dc, got_ic;

    repeat (3) tick();
    chk("reset ic_rdy", 128'(ic_rdy), 128'(0));
    chk("reset dc_rdy", 128'(dc_rdy), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset ic_data", ic_data, 128'(0));
    chk("reset dc_data", dc_data, 128'(0));
    reset = 1'b0;
    tick();

    // Writeback onto the very line being filled returns the written data.
    txn(1'b1, 32'h40, 1'b1, 32'h40, LINE_AD, 10, LINE_AD, 1'b0, "preset_40");
    txn(1'b1, 32'h40, 1'b0, 32'h0,  '0,      5,  LINE_AD, 1'b0, "dc_fill_40");
    txn(1'b1, 32'h80, 1'b1, 32'h80, LINE_W80, 10, LINE_W80, 1'b0, "dc_wb_80");
    txn(1'b0, 32'h80, 1'b0, 32'h0,  '0,      5,  LINE_W80, 1'b0, "ic_fill_80");

    // Both caches request together: dCache first, iCache after one idle cycle.
    dc_req = 1'b1; dc_addr = 32'h40; dc_wb = 1'b0;
    ic_req = 1'b1; ic_addr = 32'h80;
    tick();
    dc_at = -1; ic_at = -1; dc_cnt = 0; ic_cnt = 0; busy_bad = 0; both = 0;
    got_dc = '0; got_ic = '0;
    if (busy !== 1'b1) busy_bad++;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (busy !== ((c == 6 || c >= 13) ? 1'b0 : 1'b1)) busy_bad++;
      if (dc_rdy && ic_rdy) both++;
      if (dc_rdy) begin
        dc_cnt++;
        if (dc_at < 0) dc_at = c;
        got_dc = dc_data;
        dc_req = 1'b0;
      end
      if (ic_rdy) begin
        ic_cnt++;
        if (ic_at < 0) ic_at = c;
        got_ic = ic_data;
        ic_req = 1'b0;
      end
    end
    chk("arb dc_rdy_cycle", 128'(dc_at), 128'(5));
    chk("arb ic_rdy_cycle", 128'(ic_at), 128'(12));
    chk("arb dc_pulses", 128'(dc_cnt), 128'(1));
    chk("arb ic_pulses", 128'(ic_cnt), 128'(1));
    chk("arb both_rdy", 128'(both), 128'(0));
    chk("arb busy_profile", 128'(busy_bad), 128'(0));
    chk("arb dc_data", got_dc, LINE_AD);
    chk("arb ic_data", got_ic, LINE_W80);

    // Upper-bit aliases and byte offset 0xF land on line 4.
    txn(1'b0, 32'h0004_004F, 1'b0, 32'h0, '0, 5, LINE_AD, 1'b0, "ic_alias");
    txn(1'b1, 32'hFFFF_004F, 1'b0, 32'h0, '0, 5, LINE_AD, 1'b0, "dc_alias");

    // Inputs changed after acceptance must not affect the service.
    txn(1'b0, 32'h40, 1'b0, 32'h0, '0, 5, LINE_AD,  1'b1, "ic_disturb");
    txn(1'b1, 32'h80, 1'b0, 32'h0, '0, 5, LINE_W80, 1'b1, "dc_disturb");
    txn(1'b0, 32'h40, 1'b0, 32'h0, '0, 5, LINE_AD,  1'b0, "line4_intact");

    // Reset in the middle of a writeback aborts it without touching memory.
    txn(1'b1, 32'h100, 1'b1, 32'h100, LINE_P, 10, LINE_P, 1'b0, "preset_100");
    dc_req = 1'b1; dc_addr = 32'h40; dc_wb = 1'b1;
    dc_wb_addr = 32'h100; dc_wb_data = LINE_Q;
    tick();
    repeat (3) tick();
    reset = 1'b1;
    dc_req = 1'b0;
    dc_wb = 1'b0;
    tick();
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort dc_rdy", 128'(dc_rdy), 128'(0));
    chk("abort dc_data", dc_data, 128'(0));
    chk("abort ic_data", ic_data, 128'(0));
    reset = 1'b0;
    dc_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (dc_rdy || ic_rdy || busy) dc_cnt++;
    end
    chk("abort quiet", 128'(dc_cnt), 128'(0));
    txn(1'b1, 32'h100, 1'b0, 32'h0, '0, 5, LINE_P, 1'b0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
